// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, selectable standard or
// first-word-fall-through read mode, sticky error flags and synchronous flush.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   clear_i         synchronous flush (priority over reads and writes)
//   wr_en_i         write request, write_data_i stored when not full
//   rd_en_i         read request (FWFT=0) / pop of the head word (FWFT=1)
//   read_data_o     read data; read_valid_o qualifies it
//   full_o, empty_o, almost_full_o, almost_empty_o, count_o
//                   status decoded from the registered occupancy count
//   overflow_o, underflow_o
//                   sticky: write while full / read while empty
module sync_fifo_fwft #(
    parameter int WIDTH           = 24,
    parameter int DEPTH           = 16,
    parameter int FWFT            = 0,
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             write_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             read_data_o,
    output logic                         read_valid_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_TH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    if (WIDTH < 1 || DEPTH < 2) begin : g_bad_geometry
        $error("sync_fifo_fwft: WIDTH must be >= 1 and DEPTH >= 2");
    end
    if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af_th
        $error("sync_fifo_fwft: ALMOST_FULL_TH outside 1..DEPTH");
    end
    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH - 1) begin : g_bad_ae_th
        $error("sync_fifo_fwft: ALMOST_EMPTY_TH outside 0..DEPTH-1");
    end

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_acc, rd_acc;
    logic             full_w, empty_w;
    logic [WIDTH-1:0] head;

    assign head    = mem_q[rd_ptr_q];
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    always_comb begin
        wr_acc   = wr_en_i && !full_w && !clear_i;
        rd_acc   = rd_en_i && !empty_w && !clear_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            // In fall-through mode the visible head is latched so the
            // output word does not change when the FIFO is flushed.
            if (FWFT != 0 && !empty_w) begin
                data_d = head;
            end
        end else begin
            if (wr_acc) begin
                wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
                // Standard mode: registered read data. FWFT mode: the
                // popped word is kept for display while the FIFO is empty.
                data_d   = head;
            end
            valid_d = rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en_i && full_w) begin
                ovf_d = 1'b1;
            end
            if (rd_en_i && empty_w) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= write_data_i;
        end
    end

    assign read_data_o    = (FWFT != 0 && !empty_w) ? head : data_q;
    assign read_valid_o   = (FWFT != 0) ? !empty_w : valid_q;
    assign full_o         = full_w;
    assign empty_o        = empty_w;
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = unf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [23:0] din = '0;

    // DEPTH=5 standard mode, thresholds 4/1
    logic [23:0] a_dout; logic a_rv, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [2:0]  a_cnt;
    // DEPTH=5 fall-through mode
    logic [23:0] f_dout; logic f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [2:0]  f_cnt;
    // DEPTH=16 standard mode, default thresholds 14/2
    logic [23:0] b_dout; logic b_rv, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [4:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.WIDTH(24), .DEPTH(5), .FWFT(0), .ALMOST_FULL_TH(4), .ALMOST_EMPTY_TH(1)) u_d5 (
        .clk(clk), .rst_n(rst_n), .clear_i(clr), .wr_en_i(wr), .write_data_i(din), .rd_en_i(rd),
        .read_data_o(a_dout), .read_valid_o(a_rv), .full_o(a_full), .empty_o(a_empty),
        .almost_full_o(a_af), .almost_empty_o(a_ae), .count_o(a_cnt),
        .overflow_o(a_ovf), .underflow_o(a_unf));

    sync_fifo_fwft #(.WIDTH(24), .DEPTH(5), .FWFT(1), .ALMOST_FULL_TH(4), .ALMOST_EMPTY_TH(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .clear_i(clr), .wr_en_i(wr), .write_data_i(din), .rd_en_i(rd),
        .read_data_o(f_dout), .read_valid_o(f_rv), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .count_o(f_cnt),
        .overflow_o(f_ovf), .underflow_o(f_unf));

    sync_fifo_fwft #(.WIDTH(24), .DEPTH(16), .FWFT(0)) u_d16 (
        .clk(clk), .rst_n(rst_n), .clear_i(clr), .wr_en_i(wr), .write_data_i(din), .rd_en_i(rd),
        .read_data_o(b_dout), .read_valid_o(b_rv), .full_o(b_full), .empty_o(b_empty),
        .almost_full_o(b_af), .almost_empty_o(b_ae), .count_o(b_cnt),
        .overflow_o(b_ovf), .underflow_o(b_unf));

    typedef struct {
        logic        wr, rd, clr;
        logic [23:0] din;
        int          cnt;
        logic        full, empty, af, ae;
        logic [23:0] dout;
        logic        rv, ovf, unf;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic c, input logic [23:0] d);
        wr = w; rd = r; clr = c; din = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        drive(0, 0, 0, '0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset(input string tag, input logic [23:0] dout, input logic rv,
                             input logic full, input logic empty, input logic af,
                             input logic ae, input logic [31:0] cnt,
                             input logic ovf, input logic unf);
        chk({tag, ".dout"}, 32'(dout), 0);
        chk({tag, ".rv"}, 32'(rv), 0);
        chk({tag, ".full"}, 32'(full), 0);
        chk({tag, ".empty"}, 32'(empty), 1);
        chk({tag, ".af"}, 32'(af), 0);
        chk({tag, ".ae"}, 32'(ae), 1);
        chk({tag, ".cnt"}, cnt, 0);
        chk({tag, ".ovf"}, 32'(ovf), 0);
        chk({tag, ".unf"}, 32'(unf), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wr rd cl din        cnt full emp af ae dout       rv ovf unf
        vt.push_back('{1, 0, 0, 24'h11, 1, 0, 0, 0, 1, 24'h0,  0, 0, 0});
        vt.push_back('{1, 0, 0, 24'h22, 2, 0, 0, 0, 0, 24'h0,  0, 0, 0});
        vt.push_back('{1, 0, 0, 24'h33, 3, 0, 0, 0, 0, 24'h0,  0, 0, 0});
        vt.push_back('{1, 0, 0, 24'h44, 4, 0, 0, 1, 0, 24'h0,  0, 0, 0});
        vt.push_back('{1, 0, 0, 24'h55, 5, 1, 0, 1, 0, 24'h0,  0, 0, 0});
        vt.push_back('{1, 0, 0, 24'h66, 5, 1, 0, 1, 0, 24'h0,  0, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  4, 0, 0, 1, 0, 24'h11, 1, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  3, 0, 0, 0, 0, 24'h22, 1, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  2, 0, 0, 0, 0, 24'h33, 1, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  1, 0, 0, 0, 1, 24'h44, 1, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  0, 0, 1, 0, 1, 24'h55, 1, 1, 0});
        vt.push_back('{0, 0, 0, 24'h0,  0, 0, 1, 0, 1, 24'h55, 0, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  0, 0, 1, 0, 1, 24'h55, 0, 1, 1});
        vt.push_back('{0, 0, 1, 24'h0,  0, 0, 1, 0, 1, 24'h55, 0, 0, 0});
        vt.push_back('{1, 0, 0, 24'hA1, 1, 0, 0, 0, 1, 24'h55, 0, 0, 0});
        vt.push_back('{1, 0, 0, 24'hA2, 2, 0, 0, 0, 0, 24'h55, 0, 0, 0});
        vt.push_back('{1, 0, 0, 24'hA3, 3, 0, 0, 0, 0, 24'h55, 0, 0, 0});
        vt.push_back('{1, 0, 0, 24'hA4, 4, 0, 0, 1, 0, 24'h55, 0, 0, 0});
        vt.push_back('{1, 0, 0, 24'hA5, 5, 1, 0, 1, 0, 24'h55, 0, 0, 0});
        // full: read accepted, write rejected
        vt.push_back('{1, 1, 0, 24'hB6, 4, 0, 0, 1, 0, 24'hA1, 1, 1, 0});
        // partially full: both accepted, write lands across the wrap
        vt.push_back('{1, 1, 0, 24'hC7, 4, 0, 0, 1, 0, 24'hA2, 1, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  3, 0, 0, 0, 0, 24'hA3, 1, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  2, 0, 0, 0, 0, 24'hA4, 1, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  1, 0, 0, 0, 1, 24'hA5, 1, 1, 0});
        vt.push_back('{0, 1, 0, 24'h0,  0, 0, 1, 0, 1, 24'hC7, 1, 1, 0});
        // empty: write accepted, read rejected
        vt.push_back('{1, 1, 0, 24'hD8, 1, 0, 0, 0, 1, 24'hC7, 0, 1, 1});
        vt.push_back('{0, 1, 0, 24'h0,  0, 0, 1, 0, 1, 24'hD8, 1, 1, 1});
        // clear beats a simultaneous write
        vt.push_back('{1, 0, 1, 24'hE9, 0, 0, 1, 0, 1, 24'hD8, 0, 0, 0});
        vt.push_back('{0, 0, 0, 24'h0,  0, 0, 1, 0, 1, 24'hD8, 0, 0, 0});

        reset_all();
        chk_reset("rst.d5", a_dout, a_rv, a_full, a_empty, a_af, a_ae, 32'(a_cnt), a_ovf, a_unf);

        // Table: DEPTH=5 standard mode
        foreach (vt[i]) begin
            drive(vt[i].wr, vt[i].rd, vt[i].clr, vt[i].din);
            step();
            chk($sformatf("v%0d.cnt", i),   32'(a_cnt),   32'(vt[i].cnt));
            chk($sformatf("v%0d.full", i),  32'(a_full),  32'(vt[i].full));
            chk($sformatf("v%0d.empty", i), 32'(a_empty), 32'(vt[i].empty));
            chk($sformatf("v%0d.af", i),    32'(a_af),    32'(vt[i].af));
            chk($sformatf("v%0d.ae", i),    32'(a_ae),    32'(vt[i].ae));
            chk($sformatf("v%0d.dout", i),  32'(a_dout),  32'(vt[i].dout));
            chk($sformatf("v%0d.rv", i),    32'(a_rv),    32'(vt[i].rv));
            chk($sformatf("v%0d.ovf", i),   32'(a_ovf),   32'(vt[i].ovf));
            chk($sformatf("v%0d.unf", i),   32'(a_unf),   32'(vt[i].unf));
        end
        drive(0, 0, 0, '0);

        // Wrap: four rounds of 3 writes / 3 reads on DEPTH=5
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                drive(1, 0, 0, 24'(8'h10 * (r + 1) + k));
                step();
            end
            chk($sformatf("wrap%0d.cnt3", r), 32'(a_cnt), 3);
            for (int k = 0; k < 3; k++) begin
                drive(0, 1, 0, '0);
                step();
                chk($sformatf("wrap%0d.rd%0d", r, k), 32'(a_dout), 32'(8'h10 * (r + 1) + k));
            end
            chk($sformatf("wrap%0d.cnt0", r), 32'(a_cnt), 0);
            drive(0, 0, 0, '0);
        end

        // Fall-through mode
        reset_all();
        chk_reset("rst.fw", f_dout, f_rv, f_full, f_empty, f_af, f_ae, 32'(f_cnt), f_ovf, f_unf);
        drive(1, 0, 0, 24'hABCDEF);
        step();
        drive(0, 0, 0, '0);
        chk("fw.rv_after_wr", 32'(f_rv), 1);
        chk("fw.dout_after_wr", 32'(f_dout), 32'hABCDEF);
        chk("fw.std_rv_no_rd", 32'(a_rv), 0);
        step();
        chk("fw.dout_hold", 32'(f_dout), 32'hABCDEF);
        drive(0, 1, 0, '0);
        step();
        drive(0, 0, 0, '0);
        chk("fw.empty_after_pop", 32'(f_empty), 1);
        chk("fw.rv_after_pop", 32'(f_rv), 0);
        chk("fw.dout_last_popped", 32'(f_dout), 32'hABCDEF);
        drive(1, 0, 0, 24'h111111);
        step();
        chk("fw.head1", 32'(f_dout), 32'h111111);
        drive(1, 0, 0, 24'h222222);
        step();
        chk("fw.head1_stays", 32'(f_dout), 32'h111111);
        drive(0, 1, 0, '0);
        step();
        chk("fw.head2", 32'(f_dout), 32'h222222);
        chk("fw.rv_head2", 32'(f_rv), 1);
        step();
        drive(0, 0, 0, '0);
        chk("fw.empty2", 32'(f_empty), 1);
        chk("fw.dout_hold2", 32'(f_dout), 32'h222222);

        // DEPTH=16 thresholds 14/2
        reset_all();
        for (int i = 0; i < 14; i++) begin
            drive(1, 0, 0, 24'(i + 1));
            step();
            if (i == 12) begin
                chk("d16.af_at13", 32'(b_af), 0);
            end
        end
        chk("d16.cnt14", 32'(b_cnt), 14);
        chk("d16.af_at14", 32'(b_af), 1);
        chk("d16.full_at14", 32'(b_full), 0);
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 0, '0);
            step();
            chk($sformatf("d16.rd%0d", i), 32'(b_dout), 32'(i + 1));
            if (i == 10) begin
                chk("d16.ae_at3", 32'(b_ae), 0);
            end
        end
        chk("d16.cnt2", 32'(b_cnt), 2);
        chk("d16.ae_at2", 32'(b_ae), 1);
        chk("d16.af_at2", 32'(b_af), 0);
        step();
        step();
        chk("d16.empty", 32'(b_empty), 1);
        chk("d16.unf_before", 32'(b_unf), 0);
        step();
        drive(0, 0, 0, '0);
        chk("d16.unf_set", 32'(b_unf), 1);
        chk("d16.dout_unchanged", 32'(b_dout), 32'd14);
        chk("d16.rv_underflow", 32'(b_rv), 0);

        // Clear with write at count 7
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 0, 24'(8'h70 + i));
            step();
        end
        chk("clr.cnt7", 32'(b_cnt), 7);
        drive(1, 0, 1, 24'hFFFFFF);
        step();
        drive(0, 0, 0, '0);
        chk("clr.cnt", 32'(b_cnt), 0);
        chk("clr.empty", 32'(b_empty), 1);
        chk("clr.ovf", 32'(b_ovf), 0);
        chk("clr.unf", 32'(b_unf), 0);
        step();
        chk("clr.write_dropped", 32'(b_cnt), 0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 24'(8'h90 + i));
            step();
        end
        drive(0, 1, 0, '0);
        step();
        chk("arst.pre_cnt", 32'(b_cnt), 2);
        rst_n = 1'b0;
        #1;
        chk_reset("arst.d5", a_dout, a_rv, a_full, a_empty, a_af, a_ae, 32'(a_cnt), a_ovf, a_unf);
        chk_reset("arst.fw", f_dout, f_rv, f_full, f_empty, f_af, f_ae, 32'(f_cnt), f_ovf, f_unf);
        chk_reset("arst.d16", b_dout, b_rv, b_full, b_empty, b_af, b_ae, 32'(b_cnt), b_ovf, b_unf);
        drive(0, 0, 0, '0);
        step();
        rst_n = 1'b1;
        drive(1, 0, 0, 24'h5A5A5A);
        step();
        drive(0, 1, 0, '0);
        step();
        drive(0, 0, 0, '0);
        chk("arst.first_word", 32'(b_dout), 32'h5A5A5A);
        chk("arst.cnt_after", 32'(b_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
